// File: rtl/vr_downsizer.sv
// Valid/ready width-down converter: one wide word in, RATIO narrow beats out,
// least-significant slice first, with a last-beat flag and no inter-word bubble.
module vr_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 valid_up_in,
    output logic                 ready_up_out,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 valid_down_out,
    output logic                 last_out,
    input  logic                 ready_down_in
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if ((OUT_WIDTH > IN_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_width
            $error("vr_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [IN_WIDTH-1:0] r_word;
    logic [CNT_W-1:0]    r_cnt;

    logic w_busy;
    logic w_last;
    logic w_up_fire;
    logic w_down_fire;

    assign w_busy      = (r_state == SEND);
    assign w_last      = w_busy && (r_cnt == LAST_CNT);
    // Reload in the last-beat cycle keeps the output stream gap-free.
    assign ready_up_out = rst_n && (!w_busy || (ready_down_in && w_last));
    assign w_up_fire   = valid_up_in && ready_up_out;
    assign w_down_fire = w_busy && ready_down_in;

    assign valid_down_out = w_busy;
    assign last_out       = w_last;
    assign data_out       = r_word[r_cnt*OUT_WIDTH +: OUT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_up_fire) begin
                        r_word  <= data_in;
                        r_cnt   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_down_fire) begin
                        if (!w_last) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else if (w_up_fire) begin
                            r_word <= data_in;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vr_downsizer.sv
// Bench for vr_downsizer: 32->8 and 16->16 instances against a beat-queue
// scoreboard fed by upstream word sources.
module tb_vr_downsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_din = '0;
    logic        a_vin = 1'b0;
    logic        a_rdy = 1'b0;
    logic        a_rup, a_vout, a_last;
    logic [7:0]  a_dout;

    logic [15:0] b_din = '0;
    logic        b_vin = 1'b0;
    logic        b_rdy = 1'b0;
    logic        b_rup, b_vout, b_last;
    logic [15:0] b_dout;

    vr_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .data_in(a_din), .valid_up_in(a_vin), .ready_up_out(a_rup),
        .data_out(a_dout), .valid_down_out(a_vout), .last_out(a_last),
        .ready_down_in(a_rdy)
    );

    vr_downsizer #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .data_in(b_din), .valid_up_in(b_vin), .ready_up_out(b_rup),
        .data_out(b_dout), .valid_down_out(b_vout), .last_out(b_last),
        .ready_down_in(b_rdy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] src_a[$];
    logic [15:0] src_b[$];
    logic [8:0]  qa[$];
    logic [16:0] qb[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit oa, input bit ra, input bit ob, input bit rb);
        bit up_a, dn_a, up_b, dn_b;
        @(negedge clk);
        a_vin = oa && (src_a.size() != 0);
        a_din = (src_a.size() != 0) ? src_a[0] : 32'h0;
        a_rdy = ra;
        b_vin = ob && (src_b.size() != 0);
        b_din = (src_b.size() != 0) ? src_b[0] : 16'h0;
        b_rdy = rb;
        #1;
        check("a_valid", 32'(a_vout), 32'(qa.size() != 0));
        check("a_last", 32'(a_last), (qa.size() != 0) ? 32'(qa[0][8]) : 32'h0);
        if (qa.size() != 0) check("a_data", 32'(a_dout), 32'(qa[0][7:0]));
        check("a_ready", 32'(a_rup),
              32'(rst_n && (qa.size() == 0 || (ra && qa.size() == 1))));
        check("b_valid", 32'(b_vout), 32'(qb.size() != 0));
        check("b_last", 32'(b_last), 32'(qb.size() != 0));
        if (qb.size() != 0) check("b_data", 32'(b_dout), 32'(qb[0][15:0]));
        check("b_ready", 32'(b_rup), 32'(rst_n && (qb.size() == 0 || rb)));
        dn_a = a_vout && ra;
        up_a = a_vin && a_rup;
        dn_b = b_vout && rb;
        up_b = b_vin && b_rup;
        if (dn_a && qa.size() != 0) void'(qa.pop_front());
        if (up_a) begin
            for (int i = 0; i < 4; i++) qa.push_back({i == 3, a_din[8*i +: 8]});
            void'(src_a.pop_front());
        end
        if (dn_b && qb.size() != 0) void'(qb.pop_front());
        if (up_b) begin
            qb.push_back({1'b1, b_din});
            void'(src_b.pop_front());
        end
    endtask

    initial begin
        #2;
        check("rst_a_ready", 32'(a_rup), 32'h0);
        check("rst_a_valid", 32'(a_vout), 32'h0);
        check("rst_a_last", 32'(a_last), 32'h0);
        check("rst_a_data", 32'(a_dout), 32'h0);
        check("rst_b_ready", 32'(b_rup), 32'h0);
        check("rst_b_valid", 32'(b_vout), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single word, then back-to-back words
        src_a.push_back(32'hDDCCBBAA);
        src_b.push_back(16'hBEEF);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1);
        src_a.push_back(32'h44332211);
        src_a.push_back(32'h88776655);
        for (int i = 1; i <= 5; i++) src_b.push_back(16'(i));
        for (int i = 0; i < 10; i++) step(1, 1, 1, 1);

        // downstream backpressure on the second beat
        src_a.push_back(32'hDDCCBBAA);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);

        // upstream word offered while busy and stalled
        src_a.push_back(32'hA1A2A3A4);
        src_a.push_back(32'h12345678);
        step(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 1);

        // asynchronous reset in the middle of a word
        src_a.push_back(32'hDDCCBBAA);
        src_b.push_back(16'hCAFE);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", 32'(a_vout), 32'h0);
        check("mid_rst_a_last", 32'(a_last), 32'h0);
        check("mid_rst_a_data", 32'(a_dout), 32'h0);
        check("mid_rst_a_ready", 32'(a_rup), 32'h0);
        check("mid_rst_b_valid", 32'(b_vout), 32'h0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
        src_a.push_back(32'h0F0E0D0C);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (src_a.size() < 3 && $urandom_range(0, 3) == 0) src_a.push_back($urandom);
            if (src_b.size() < 3 && $urandom_range(0, 2) == 0)
                src_b.push_back(16'($urandom_range(0, 65535)));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 40; i++) step(1, 1, 1, 1);
        check("a_drained", 32'(qa.size() + src_a.size()), 32'h0);
        check("b_drained", 32'(qb.size() + src_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
